nios_system_onchip_mem_bridge: RTL and testbench
================================================

Name: nios_system_onchip_mem_bridge

Overview:
Pipelined Avalon-MM slave-to-memory bridge that sits directly upstream of the 12288x32 single-port on-chip RAM (altsyncram, clock-enabled, unregistered q, 1-cycle read latency). It registers each command and drives the RAM port. It tracks in-flight reads and returns registered read data with readdatavalid. It also adds freeze stalling, out-of-range and write-protect checking, and an error counter for the Nios data master.

Parameters:
DEPTH, 12288, number of valid 32-bit words; word addresses >= DEPTH are out of range.
ADDR_W, 14, word-address width on both sides.
ERR_DATA, 32'hDEADBEEF, readdata returned for an out-of-range read.
WP_LIMIT, 1024, when wp_enable=1, word addresses < WP_LIMIT reject writes.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
s_address  in  ADDR_W  upstream word address.
s_byteenable  in  4  upstream byte enables.
s_read  in  1  upstream read request.
s_write  in  1  upstream write request.
s_writedata  in  32  upstream write data.
s_waitrequest  out  1  command not accepted this cycle.
s_readdata  out  32  registered read data.
s_readdatavalid  out  1  one-cycle pulse qualifying s_readdata.
freeze  in  1  stall request; gates the RAM clock enable.
wp_enable  in  1  enables the write-protect region.
err_clear  in  1  synchronous clear of err_count and err_flag.
err_count  out  16  saturating count of rejected accesses.
err_flag  out  1  sticky flag, set on any rejected access.
m_address  out  ADDR_W  RAM address.
m_byteenable  out  4  RAM byte enables.
m_chipselect  out  1  RAM chipselect.
m_write  out  1  RAM write.
m_writedata  out  32  RAM write data.
m_clken  out  1  RAM clock enable; equals ~freeze.
m_readdata  in  32  RAM q (valid the cycle after the address is sampled).

Behaviour:
- Reset (async):
  - Clears cmd_valid, rd_p2, s_readdatavalid, err_count and err_flag.
  - s_readdata=0 and all m_* outputs=0.
  - m_clken follows ~freeze; it is combinational and not reset.
- Accept:
  - s_waitrequest = freeze.
  - A command is accepted when (s_read|s_write) & ~s_waitrequest.
  - s_read and s_write both high is illegal; the bridge treats it as a write.
- Command register:
  - On accept, the bridge captures address, byteenable, writedata and type, and sets cmd_valid.
  - With no accept and ~freeze, cmd_valid clears.
  - With freeze, the register holds.
- RAM drive (from command register):
  - m_chipselect = cmd_valid & in_range & ~protected_write.
  - m_write = m_chipselect & cmd_write.
  - m_address, m_byteenable and m_writedata are driven from the register.
  - in_range = (addr < DEPTH).
  - protected_write = cmd_write & wp_enable & (addr < WP_LIMIT).
- Read tracking, on each ~freeze cycle:
  - rd_p2 <= cmd_valid & cmd_read.
  - oor_p2 <= ~in_range.
  - s_readdatavalid <= rd_p2.
  - s_readdata <= oor_p2 ? ERR_DATA : m_readdata (captured only when rd_p2).
- Freeze behaviour:
  - On freeze cycles, rd_p2 and oor_p2 hold and s_readdatavalid <= 0.
  - The RAM holds q because clken=0, so data captured after unfreeze is correct.
- Latency:
  - Read accepted at cycle 0 → s_readdatavalid high in cycle 3, plus one cycle per freeze cycle in between.
  - Writes take effect in RAM at the end of cycle 1.
  - Back-to-back reads give one valid per cycle, in order.
- Errors:
  - Counted once, at the cycle the command sits in the register with ~freeze.
  - Error conditions: out-of-range read or write, and protected write.
  - err_count saturates at 16'hFFFF.
  - err_flag is sticky.
  - err_clear has priority over a same-cycle increment (result 0/0).
- Dropped writes: rejected writes never assert m_chipselect and produce no response.
- Mid-operation reset: in-flight reads are discarded and no readdatavalid follows.

Test Plan:
1. Write 0x12345678 to word 5 (be=4'hF), then read word 5 → s_readdatavalid 3 cycles after read accept, s_readdata=0x12345678, err_count=0.
2. Read words 0,1,2,3 on consecutive cycles after preloading 0xA0..0xA3 → four consecutive valid pulses, data in order.
3. Read word 100, freeze high for 2 cycles starting the cycle after accept → valid at cycle 5, correct data; s_waitrequest=1 and m_clken=0 during freeze.
4. Write word 12288 and read word 13000 → no m_chipselect; read returns 0xDEADBEEF; err_count=2, err_flag=1; err_clear → 0/0.
5. wp_enable=1: write 0xFFFFFFFF to word 10 (below WP_LIMIT), then read word 10 → old value returned, err_count=1; writing word 1024 succeeds.
6. Assert reset one cycle after a read accept → no s_readdatavalid ever; all outputs at reset values; the next read works normally.

Source files
------------

// File: rtl/nios_system_onchip_mem_bridge.sv
// Pipelined Avalon-MM slave to on-chip RAM bridge.
// Registers each accepted command and drives the single-port RAM from that
// register. It returns read data two cycles after the command register stage,
// for a total of three cycles from accept to readdatavalid. It also checks the
// address range and the write-protect window, and counts rejected accesses.
// freeze stalls the whole pipeline, including the RAM itself through clken.
module nios_system_onchip_mem_bridge #(
    parameter int          DEPTH    = 12288,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter int          WP_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [3:0]        s_byteenable,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic              s_waitrequest,
    output logic [31:0]       s_readdata,
    output logic              s_readdatavalid,
    input  logic              freeze,
    input  logic              wp_enable,
    input  logic              err_clear,
    output logic [15:0]       err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata
);

    // One extra bit so that a limit equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] WP_L    = (ADDR_W+1)'(WP_LIMIT);

    logic              cmd_valid_reg;
    logic              cmd_write_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [3:0]        cmd_be_reg;
    logic [31:0]       cmd_wdata_reg;

    logic              rd_p2_reg;
    logic              oor_p2_reg;
    logic [31:0]       s_readdata_reg;
    logic              s_readdatavalid_reg;

    logic [15:0]       err_count_reg;
    logic              err_flag_reg;

    logic              accept;
    logic              in_range;
    logic              protected_write;
    logic              cmd_read;
    logic              err_event;

    // A simultaneous read and write is illegal upstream; treating it as a
    // write falls out of capturing s_write as the command type.
    assign s_waitrequest   = freeze;
    assign accept          = (s_read | s_write) & ~freeze;
    assign cmd_read        = ~cmd_write_reg;
    assign in_range        = ({1'b0, cmd_addr_reg} < DEPTH_L);
    assign protected_write = cmd_write_reg & wp_enable & ({1'b0, cmd_addr_reg} < WP_L);
    // Stalled cycles do not count, so a frozen command is counted exactly once.
    assign err_event       = cmd_valid_reg & ~freeze & (~in_range | protected_write);

    assign m_clken         = ~freeze;
    assign m_chipselect    = cmd_valid_reg & in_range & ~protected_write;
    assign m_write         = m_chipselect & cmd_write_reg;
    assign m_address       = cmd_addr_reg;
    assign m_byteenable    = cmd_be_reg;
    assign m_writedata     = cmd_wdata_reg;

    assign s_readdata      = s_readdata_reg;
    assign s_readdatavalid = s_readdatavalid_reg;
    assign err_count       = err_count_reg;
    assign err_flag        = err_flag_reg;

    // Command register: capture on accept, drain when idle, hold while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid_reg <= 1'b0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_be_reg    <= '0;
            cmd_wdata_reg <= '0;
        end else if (accept) begin
            cmd_valid_reg <= 1'b1;
            cmd_write_reg <= s_write;
            cmd_addr_reg  <= s_address;
            cmd_be_reg    <= s_byteenable;
            cmd_wdata_reg <= s_writedata;
        end else if (!freeze) begin
            cmd_valid_reg <= 1'b0;
        end
    end

    // Read return pipeline: mark the RAM-access stage, then register q (or the
    // error pattern) one cycle later. Frozen cycles hold the markers and
    // suppress the valid pulse; the RAM keeps q stable because clken is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_p2_reg           <= 1'b0;
            oor_p2_reg          <= 1'b0;
            s_readdata_reg      <= '0;
            s_readdatavalid_reg <= 1'b0;
        end else if (freeze) begin
            s_readdatavalid_reg <= 1'b0;
        end else begin
            rd_p2_reg           <= cmd_valid_reg & cmd_read;
            oor_p2_reg          <= ~in_range;
            s_readdatavalid_reg <= rd_p2_reg;
            if (rd_p2_reg) begin
                s_readdata_reg <= oor_p2_reg ? ERR_DATA : m_readdata;
            end
        end
    end

    // Error statistics: clear wins over a same-cycle increment; count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_reg <= '0;
            err_flag_reg  <= 1'b0;
        end else if (err_clear) begin
            err_count_reg <= '0;
            err_flag_reg  <= 1'b0;
        end else if (err_event) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            err_flag_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios_system_onchip_mem_bridge.sv
// Testbench for nios_system_onchip_mem_bridge with a behavioural 12288x32
// clock-enabled RAM (1-cycle read latency, unregistered q) on the m_* side.
module tb_nios_system_onchip_mem_bridge;

    localparam int OP_W = 0;
    localparam int OP_R = 1;
    localparam int OP_C = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        freeze;
    logic        wp_enable;
    logic        err_clear;
    logic [15:0] err_count;
    logic        err_flag;
    logic [13:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata;

    int n_vec  = 0;
    int n_fail = 0;

    nios_system_onchip_mem_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .s_address       (s_address),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .freeze          (freeze),
        .wp_enable       (wp_enable),
        .err_clear       (err_clear),
        .err_count       (err_count),
        .err_flag        (err_flag),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural on-chip RAM.
    logic [31:0] mem [0:12287];
    logic [31:0] ram_q;
    assign m_readdata = ram_q;

    initial begin
        for (int i = 0; i < 12288; i++) mem[i] = 32'h0;
        ram_q = 32'h0;
    end

    always @(posedge clk) begin
        if (m_clken && m_chipselect && (m_address < 14'd12288)) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_byteenable[b]) mem[m_address][b*8 +: 8] <= m_writedata[b*8 +: 8];
                end
            end
            ram_q <= mem[m_address];
        end
    end

    typedef struct {
        int          op;
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wp;
        logic        exp_cs;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_flag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int op, input logic [13:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic wp, input logic exp_cs,
                       input logic [31:0] exp_rd, input logic [15:0] exp_cnt,
                       input logic exp_flag);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.be = be; v.wp = wp;
        v.exp_cs = exp_cs; v.exp_rd = exp_rd; v.exp_cnt = exp_cnt; v.exp_flag = exp_flag;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write; report what the RAM port showed in the cycle after accept.
    task automatic do_write(input logic [13:0] addr, input logic [31:0] data,
                            input logic [3:0] be, output logic cs, output logic mw);
        s_address = addr; s_writedata = data; s_byteenable = be; s_write = 1'b1;
        tick();
        s_write = 1'b0;
        cs = m_chipselect;
        mw = m_write;
    endtask

    // Issue a read; return the data and the number of cycles to readdatavalid.
    task automatic do_read(input logic [13:0] addr, output logic [31:0] data, output int lat);
        s_address = addr; s_byteenable = 4'hF; s_read = 1'b1;
        tick();
        s_read = 1'b0;
        lat = 1;
        while (!s_readdatavalid && lat < 12) begin
            tick();
            lat++;
        end
        data = s_readdata;
    endtask

    initial begin
        logic        cs, mw;
        logic [31:0] rd;
        int          lat;

        reset = 1'b1; s_address = '0; s_byteenable = 4'hF; s_read = 1'b0; s_write = 1'b0;
        s_writedata = '0; freeze = 1'b0; wp_enable = 1'b0; err_clear = 1'b0;

        //   op    addr      data          be     wp  cs   exp_rd        cnt  flag
        add(OP_W, 14'd5,     32'h12345678, 4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_R, 14'd5,     32'h0,        4'hF, 0, 0, 32'h12345678, 0, 0);
        add(OP_W, 14'd0,     32'hA0,       4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd1,     32'hA1,       4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd2,     32'hA2,       4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd3,     32'hA3,       4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd100,   32'h10000064, 4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd6,     32'hFFFFFFFF, 4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd6,     32'h000000AB, 4'h1, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd6,     32'h00CD0000, 4'h4, 0, 1, 32'h0,        0, 0);
        add(OP_R, 14'd6,     32'h0,        4'hF, 0, 0, 32'hFFCDFFAB, 0, 0);
        add(OP_W, 14'd12288, 32'h11111111, 4'hF, 0, 0, 32'h0,        1, 1);
        add(OP_R, 14'd13000, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 2, 1);
        add(OP_C, 14'd0,     32'h0,        4'hF, 0, 0, 32'h0,        0, 0);
        add(OP_W, 14'd10,    32'h00000055, 4'hF, 0, 1, 32'h0,        0, 0);
        add(OP_W, 14'd10,    32'hFFFFFFFF, 4'hF, 1, 0, 32'h0,        1, 1);
        add(OP_R, 14'd10,    32'h0,        4'hF, 1, 0, 32'h00000055, 1, 1);
        add(OP_W, 14'd1024,  32'h0000CAFE, 4'hF, 1, 1, 32'h0,        1, 1);
        add(OP_R, 14'd1024,  32'h0,        4'hF, 1, 0, 32'h0000CAFE, 1, 1);
        add(OP_W, 14'd1023,  32'h77777777, 4'hF, 1, 0, 32'h0,        2, 1);
        add(OP_W, 14'd12287, 32'h0BADF00D, 4'hF, 0, 1, 32'h0,        2, 1);
        add(OP_R, 14'd12287, 32'h0,        4'hF, 0, 0, 32'h0BADF00D, 2, 1);
        add(OP_R, 14'd12288, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 3, 1);
        add(OP_C, 14'd0,     32'h0,        4'hF, 0, 0, 32'h0,        0, 0);

        // Reset state.
        #2;
        chk("rst_valid", {31'b0, s_readdatavalid}, 32'h0);
        chk("rst_rdata", s_readdata, 32'h0);
        chk("rst_cs",    {31'b0, m_chipselect}, 32'h0);
        chk("rst_maddr", {18'b0, m_address}, 32'h0);
        chk("rst_errc",  {16'b0, err_count}, 32'h0);
        chk("rst_clken", {31'b0, m_clken}, 32'h1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Table-driven single transactions.
        foreach (tbl[i]) begin
            wp_enable = tbl[i].wp;
            case (tbl[i].op)
                OP_W: begin
                    do_write(tbl[i].addr, tbl[i].data, tbl[i].be, cs, mw);
                    chk($sformatf("v%0d_cs", i), {31'b0, cs}, {31'b0, tbl[i].exp_cs});
                    chk($sformatf("v%0d_mwrite", i), {31'b0, mw}, {31'b0, tbl[i].exp_cs});
                end
                OP_R: begin
                    do_read(tbl[i].addr, rd, lat);
                    chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
                    chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
                end
                default: begin
                    err_clear = 1'b1;
                    tick();
                    err_clear = 1'b0;
                end
            endcase
            tick(); tick();
            chk($sformatf("v%0d_errcnt", i), {16'b0, err_count}, {16'b0, tbl[i].exp_cnt});
            chk($sformatf("v%0d_errflag", i), {31'b0, err_flag}, {31'b0, tbl[i].exp_flag});
            wp_enable = 1'b0;
        end

        // Back-to-back reads of words 0..3: valids in cycles 3..6, in order.
        for (int c = 0; c < 10; c++) begin
            s_read = (c < 4);
            s_address = 14'(c);
            #1;
            chk($sformatf("b2b_valid_c%0d", c), {31'b0, s_readdatavalid},
                {31'b0, (c >= 3 && c <= 6)});
            if (c >= 3 && c <= 6) chk($sformatf("b2b_data_c%0d", c), s_readdata, 32'hA0 + 32'(c - 3));
            tick();
        end
        s_read = 1'b0;

        // Read word 100 with freeze in cycles 1 and 2: valid moves to cycle 5.
        s_address = 14'd100; s_read = 1'b1;
        tick();
        s_read = 1'b0;
        for (int c = 1; c < 8; c++) begin
            freeze = (c == 1 || c == 2);
            #1;
            chk($sformatf("frz_wait_c%0d", c), {31'b0, s_waitrequest}, {31'b0, freeze});
            chk($sformatf("frz_clken_c%0d", c), {31'b0, m_clken}, {31'b0, ~freeze});
            chk($sformatf("frz_valid_c%0d", c), {31'b0, s_readdatavalid}, {31'b0, (c == 5)});
            if (c == 5) chk("frz_data", s_readdata, 32'h10000064);
            tick();
        end
        freeze = 1'b0;

        // Mid-operation reset: in-flight read discarded, error state cleared.
        do_write(14'd14000, 32'h0, 4'hF, cs, mw);
        tick(); tick();
        chk("pre_rst_errcnt", {16'b0, err_count}, 32'h1);
        s_address = 14'd5; s_read = 1'b1;
        tick();
        s_read = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_cs",    {31'b0, m_chipselect}, 32'h0);
        chk("mrst_maddr", {18'b0, m_address}, 32'h0);
        chk("mrst_rdata", s_readdata, 32'h0);
        chk("mrst_errc",  {16'b0, err_count}, 32'h0);
        chk("mrst_errf",  {31'b0, err_flag}, 32'h0);
        tick();
        reset = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                if (s_readdatavalid) seen++;
                tick();
            end
            chk("mrst_no_valid", 32'(seen), 32'd0);
        end
        do_read(14'd5, rd, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_data", rd, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
